// File: rtl/pipeline_hazard_ctrl.sv
// EX/ID pipeline control for the 5-stage RV32I core: branch/jump redirect,
// operand forwarding selects, load-use stall and a sticky halt flag.
module pipeline_hazard_ctrl #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   ex_rs1,
  input  logic [RA_W-1:0]   ex_rs2,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic              wb_reg_write,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0] ex_imm,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic              ex_jalr,
  input  logic              ex_halt,
  input  logic [DATA_W-1:0] ex_rs1_data,
  input  logic [DATA_W-1:0] ex_alu_result,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [DATA_W-1:0] pc_imm,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] br_target,
  output logic              pc_sel,
  output logic              halted
);

  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] jalr_sum;
  logic              mem_fwd_ok;
  logic              wb_fwd_ok;

  assign pc_ext     = DATA_W'(ex_pc);
  assign mem_fwd_ok = mem_reg_write && (mem_rd != '0);
  assign wb_fwd_ok  = wb_reg_write && (wb_rd != '0);

  // EX/MEM is the younger result, so it is checked first.
  always_comb begin
    fwd_a_sel = 2'b00;
    if (mem_fwd_ok && (mem_rd == ex_rs1))
      fwd_a_sel = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rs1))
      fwd_a_sel = 2'b01;
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if (mem_fwd_ok && (mem_rd == ex_rs2))
      fwd_b_sel = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rs2))
      fwd_b_sel = 2'b01;
  end

  assign stall = ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign pc_imm   = pc_ext + ex_imm;
  assign pc_plus4 = pc_ext + DATA_W'(4);
  assign jalr_sum = ex_rs1_data + ex_imm;

  // A halt redirects to its own PC so the front end spins in place.
  always_comb begin
    br_target = pc_imm;
    if (ex_halt)
      br_target = pc_ext;
    else if (ex_jalr)
      br_target = {jalr_sum[DATA_W-1:1], 1'b0};
  end

  assign pc_sel = ex_halt | ex_jump | (ex_branch & ex_alu_result[0]);

  always_ff @(posedge clk) begin
    if (reset)
      halted <= 1'b0;
    else if (ex_halt)
      halted <= 1'b1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level
// reference model.
module tb_pipeline_hazard_ctrl;

  localparam int PC_W   = 9;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [RA_W-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              ex_mem_read, mem_reg_write, wb_reg_write;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_imm, ex_rs1_data, ex_alu_result;
  logic              ex_branch, ex_jump, ex_jalr, ex_halt;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic              stall, pc_sel, halted;
  logic [DATA_W-1:0] pc_imm, pc_plus4, br_target;

  int checks = 0;
  int errors = 0;
  bit ref_halted;

  pipeline_hazard_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_jalr(ex_jalr), .ex_halt(ex_halt), .ex_rs1_data(ex_rs1_data),
    .ex_alu_result(ex_alu_result),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .pc_imm(pc_imm), .pc_plus4(pc_plus4), .br_target(br_target),
    .pc_sel(pc_sel), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Forwarding rule: nearest writer of the source register, never x0.
  function automatic logic [1:0] ref_fwd(input int rs);
    if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_target();
    longint unsigned pc = longint'(ex_pc);
    longint unsigned s;
    if (ex_halt) return 32'(pc);
    if (ex_jalr) begin
      s = (longint'(ex_rs1_data) + longint'(ex_imm)) % 64'h1_0000_0000;
      return 32'(s - (s % 2));
    end
    return 32'((pc + longint'(ex_imm)) % 64'h1_0000_0000);
  endfunction

  task automatic check_comb();
    longint unsigned pc = longint'(ex_pc);
    bit exp_stall;
    exp_stall = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    check("fwd_a", 32'(fwd_a_sel), 32'(ref_fwd(int'(ex_rs1))));
    check("fwd_b", 32'(fwd_b_sel), 32'(ref_fwd(int'(ex_rs2))));
    check("stall", 32'(stall), 32'(exp_stall));
    check("pc_imm", pc_imm, 32'((pc + longint'(ex_imm)) % 64'h1_0000_0000));
    check("pc_plus4", pc_plus4, 32'(pc + 4));
    check("br_target", br_target, ref_target());
    check("pc_sel", 32'(pc_sel), 32'(ex_halt || ex_jump || (ex_branch && ex_alu_result[0])));
  endtask

  // Clock one edge, advance the halt model, and compare the flag.
  task automatic tick();
    @(posedge clk);
    if (reset) ref_halted = 1'b0;
    else if (ex_halt) ref_halted = 1'b1;
    #1;
    check("halted", 32'(halted), 32'(ref_halted));
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0; ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_pc = '0; ex_imm = '0; ex_rs1_data = '0; ex_alu_result = '0;
    ex_branch = 0; ex_jump = 0; ex_jalr = 0; ex_halt = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    tick();
    check("reset_halted", 32'(halted), 32'd0);
    reset = 0;

    // Forwarding priority and x0 suppression.
    mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 5; #1;
    check("fwd_a_both", 32'(fwd_a_sel), 32'h2); check_comb();
    mem_reg_write = 0; #1;
    check("fwd_a_wb", 32'(fwd_a_sel), 32'h1);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; #1;
    check("fwd_a_x0", 32'(fwd_a_sel), 32'h0);
    mem_rd = 9; ex_rs2 = 9; ex_rs1 = 3; #1;
    check("fwd_b_mem", 32'(fwd_b_sel), 32'h2); check_comb();

    // Load-use stall.
    idle(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; #1;
    check("stall_rs2", 32'(stall), 32'd1);
    ex_rd = 0; id_rs2 = 0; #1;
    check("stall_x0", 32'(stall), 32'd0);
    ex_rd = 7; id_rs2 = 7; ex_mem_read = 0; #1;
    check("stall_noload", 32'(stall), 32'd0);

    // Conditional branch, backward offset.
    idle(); ex_pc = 9'h010; ex_imm = 32'hFFFF_FFF8; ex_branch = 1; ex_alu_result = 1; #1;
    check("br_sel", 32'(pc_sel), 32'd1);
    check("br_target", br_target, 32'h008);
    check("br_plus4", pc_plus4, 32'h014);
    ex_alu_result = 0; #1;
    check("br_not_taken", 32'(pc_sel), 32'd0);

    // JALR clears bit 0 of the sum.
    idle(); ex_pc = 9'h040; ex_jump = 1; ex_jalr = 1; ex_rs1_data = 32'h101; ex_imm = 4; #1;
    check("jalr_target", br_target, 32'h104);
    check("jalr_sel", 32'(pc_sel), 32'd1);
    check("jalr_plus4", pc_plus4, 32'h044);
    ex_pc = 9'h1FF; ex_jalr = 0; ex_imm = 32'h7FFF_FFFF; #1;
    check_comb();

    // Halt: redirect to self, sticky flag, reset clears, reset wins.
    idle(); ex_pc = 9'h020; ex_halt = 1; ex_jalr = 1; #1;
    check("halt_sel", 32'(pc_sel), 32'd1);
    check("halt_target", br_target, 32'h020);
    check("halt_pre", 32'(halted), 32'd0);
    tick();
    ex_halt = 0; ex_jalr = 0;
    tick();
    check("halt_sticky", 32'(halted), 32'd1);
    reset = 1; tick();
    check("halt_cleared", 32'(halted), 32'd0);
    ex_halt = 1; tick();
    check("reset_wins", 32'(halted), 32'd0);
    reset = 0; ex_halt = 0;

    // Randomized sweep with a narrow register range to force matches.
    for (int i = 0; i < 400; i++) begin
      id_rs1 = RA_W'($urandom_range(0, 3)); id_rs2 = RA_W'($urandom_range(0, 3));
      ex_rs1 = RA_W'($urandom_range(0, 3)); ex_rs2 = RA_W'($urandom_range(0, 3));
      ex_rd = RA_W'($urandom_range(0, 3)); mem_rd = RA_W'($urandom_range(0, 3));
      wb_rd = RA_W'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom); mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      ex_pc = PC_W'($urandom); ex_imm = $urandom; ex_rs1_data = $urandom;
      ex_alu_result = $urandom; ex_branch = 1'($urandom); ex_jump = 1'($urandom);
      ex_jalr = 1'($urandom); ex_halt = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 19) == 0);
      #1;
      check_comb();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
